// File: rtl/trace_collector_pkg.sv
// Shared types and constants for the trace event collector.
// Holds event kinds, l.nop decode constants and the event record layout.
package trace_collector_pkg;

   typedef enum logic [1:0] {
      EVT_EXIT   = 2'd0,
      EVT_REPORT = 2'd1,
      EVT_PUTC   = 2'd2
   } evt_kind_t;

   localparam logic [7:0]  NOP_OPCODE = 8'h15;
   localparam logic [15:0] NOP_EXIT   = 16'h0001;
   localparam logic [15:0] NOP_REPORT = 16'h0002;
   localparam logic [15:0] NOP_PUTC   = 16'h0004;

   localparam int TRACE_DW = 32;

   // Event record for the default data width; the collector packs
   // FIFO entries in this same field order.
   typedef struct packed {
      evt_kind_t           kind;
      logic [TRACE_DW-1:0] data;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
      logic [31:0]         timestamp;
`endif
   } trace_event_t;

endpackage

// File: rtl/trace_event_fifo.sv
// Single-clock first-word-fall-through FIFO, one per monitored core.
// Ports: clk, rst (async high), push/wdata, pop, rdata, full, empty.
// A push on a full FIFO succeeds when a pop happens in the same cycle.
module trace_event_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/trace_event_collector.sv
// Detects l.nop EXIT/REPORT/PUTC on NUM_CORES trace ports, buffers them per
// core and merges them round-robin into one valid/ready event stream.
// Ports: clk, rst, trace_valid/insn/r3 in; evt_valid/ready/core/kind/data,
// overflow, terminated, all_terminated. Option TRACE_COLLECTOR_TIMESTAMP_EN
// adds a cycle counter and the evt_timestamp output.
module trace_event_collector
   import trace_collector_pkg::*;
#(
   parameter int NUM_CORES  = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_CORES-1:0]            trace_valid,
   input  logic [NUM_CORES*DATA_WIDTH-1:0] trace_insn,
   input  logic [NUM_CORES*DATA_WIDTH-1:0] trace_r3,
   output logic                            evt_valid,
   input  logic                            evt_ready,
   output logic [(NUM_CORES > 1 ? $clog2(NUM_CORES) : 1)-1:0] evt_core,
   output logic [1:0]                      evt_kind,
   output logic [DATA_WIDTH-1:0]           evt_data,
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
   output logic [31:0]                     evt_timestamp,
`endif
   output logic [NUM_CORES-1:0]            overflow,
   output logic [NUM_CORES-1:0]            terminated,
   output logic                            all_terminated
);

   localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
   localparam int EW = 2 + DATA_WIDTH + 32;
   logic [31:0] ts;
`else
   localparam int EW = 2 + DATA_WIDTH;
`endif

   logic [NUM_CORES-1:0] full, empty, pop;
   logic [NUM_CORES-1:0] exit_hit, ovf_hit;
   logic [EW-1:0]        rdata [NUM_CORES];
   logic [CW-1:0]        ptr, win;
   logic                 have_win, load;

   assign load = !evt_valid || evt_ready;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      logic [DATA_WIDTH-1:0] insn;
      logic [DATA_WIDTH-1:0] r3;
      logic                  det;
      evt_kind_t             kind;
      logic [EW-1:0]         wdata;
      logic                  unused_imm_hi;

      assign insn = trace_insn[g*DATA_WIDTH +: DATA_WIDTH];
      assign r3   = trace_r3[g*DATA_WIDTH +: DATA_WIDTH];
      assign unused_imm_hi = ^insn[23:16];

      always_comb begin
         det  = 1'b0;
         kind = EVT_EXIT;
         if (trace_valid[g] && insn[31:24] == NOP_OPCODE &&
             !terminated[g]) begin
            case (insn[15:0])
               NOP_EXIT:   begin det = 1'b1; kind = EVT_EXIT;   end
               NOP_REPORT: begin det = 1'b1; kind = EVT_REPORT; end
               NOP_PUTC:   begin det = 1'b1; kind = EVT_PUTC;   end
               default:    ;
            endcase
         end
      end

`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
      assign wdata = {kind, r3, ts};
`else
      assign wdata = {kind, r3};
`endif

      assign pop[g]      = load && have_win && (win == CW'(g));
      assign exit_hit[g] = det && (kind == EVT_EXIT);
      // A full FIFO only drops the event when it is not popped this cycle.
      assign ovf_hit[g]  = det && full[g] && !pop[g];

      trace_event_fifo #(
         .WIDTH (EW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (det),
         .wdata (wdata),
         .pop   (pop[g]),
         .rdata (rdata[g]),
         .full  (full[g]),
         .empty (empty[g])
      );
   end

   // Scan from the farthest offset down so the nearest non-empty
   // FIFO at or after ptr is the last (winning) assignment.
   always_comb begin
      int idx;
      have_win = 1'b0;
      win      = '0;
      idx      = 0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (!empty[idx]) begin
            have_win = 1'b1;
            win      = CW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid      <= 1'b0;
         evt_core       <= '0;
         evt_kind       <= '0;
         evt_data       <= '0;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
         evt_timestamp  <= '0;
`endif
         overflow       <= '0;
         terminated     <= '0;
         all_terminated <= 1'b0;
         ptr            <= '0;
      end else begin
         overflow       <= overflow | ovf_hit;
         terminated     <= terminated | exit_hit;
         all_terminated <= &terminated;
         if (load) begin
            evt_valid <= have_win;
            if (have_win) begin
               evt_core <= win;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
               {evt_kind, evt_data, evt_timestamp} <= rdata[win];
`else
               {evt_kind, evt_data} <= rdata[win];
`endif
               ptr <= (win == CW'(NUM_CORES - 1)) ? '0 : win + 1'b1;
            end
         end
      end
   end

`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts <= '0;
      else     ts <= ts + 32'd1;
   end
`endif

endmodule

// File: tb/tb_trace_event_collector.sv
// Directed self-checking bench for trace_event_collector.
// Drives a 4-core and a 1-core instance with hand-computed expectations.
module tb_trace_event_collector;

   localparam logic [31:0] I_EXIT = 32'h1500_0001;
   localparam logic [31:0] I_REP  = 32'h1500_0002;
   localparam logic [31:0] I_PUTC = 32'h1500_0004;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [3:0]   tv4;
   logic [127:0] ti4, tr4;
   logic         ev4, er4, at4;
   logic [1:0]   ec4, ek4;
   logic [31:0]  ed4;
   logic [3:0]   ov4, tm4;

   logic         tv1, ev1, er1, at1;
   logic [31:0]  ti1, tr1, ed1;
   logic [0:0]   ec1, ov1, tm1;
   logic [1:0]   ek1;
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
   logic [31:0]  ts4, ts1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   trace_event_collector #(
      .NUM_CORES(4), .FIFO_DEPTH(4), .DATA_WIDTH(32)
   ) u_dut4 (
      .clk(clk), .rst(rst), .trace_valid(tv4), .trace_insn(ti4),
      .trace_r3(tr4), .evt_valid(ev4), .evt_ready(er4),
      .evt_core(ec4), .evt_kind(ek4), .evt_data(ed4),
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
      .evt_timestamp(ts4),
`endif
      .overflow(ov4), .terminated(tm4), .all_terminated(at4)
   );

   trace_event_collector #(
      .NUM_CORES(1), .FIFO_DEPTH(4), .DATA_WIDTH(32)
   ) u_dut1 (
      .clk(clk), .rst(rst), .trace_valid(tv1), .trace_insn(ti1),
      .trace_r3(tr1), .evt_valid(ev1), .evt_ready(er1),
      .evt_core(ec1), .evt_kind(ek1), .evt_data(ed1),
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
      .evt_timestamp(ts1),
`endif
      .overflow(ov1), .terminated(tm1), .all_terminated(at1)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      tv4 = '0; ti4 = '0; tr4 = '0;
      tv1 = 1'b0; ti1 = '0; tr1 = '0;
   endtask

   task automatic put4(input int c, input logic [31:0] insn,
                       input logic [31:0] r3);
      tv4[c]         = 1'b1;
      ti4[c*32 +: 32] = insn;
      tr4[c*32 +: 32] = r3;
   endtask

   int got;
   int order [4];

   initial begin
      rst = 1'b1; er4 = 1'b0; er1 = 1'b0;
      clr();
      tick(); tick();
      check("rst_valid", ev4, 0);
      check("rst_core", ec4, 0);
      check("rst_kind", ek4, 0);
      check("rst_data", ed4, 0);
      check("rst_ovf", ov4, 0);
      check("rst_term", tm4, 0);
      check("rst_allterm", at4, 0);
      check("rst_valid1", ev1, 0);
      rst = 1'b0;
      tick();

      // single core PUTC latency
      er1 = 1'b1;
      tv1 = 1'b1; ti1 = I_PUTC; tr1 = 32'h41;
      tick(); clr();
      check("t1_not_yet", ev1, 0);
      tick();
      check("t1_valid", ev1, 1);
      check("t1_kind", ek1, 2);
      check("t1_data", ed1, 32'h41);
      check("t1_core", ec1, 0);
      tick();
      check("t1_drained", ev1, 0);
      // unknown immediate and wrong opcode are ignored
      tv1 = 1'b1; ti1 = 32'h1500_0003; tr1 = 32'h7;
      tick();
      ti1 = 32'h1400_0004;
      tick(); clr();
      tick();
      check("t1_noevt", ev1, 0);

      // simultaneous REPORT bursts, round-robin from core 0
      er4 = 1'b1;
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < 4; c++) put4(c, I_REP, 32'(b*16 + c));
         tick(); clr();
         check("t2_gap", ev4, 0);
         for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_valid", ev4, 1);
            check("t2_core", ec4, i);
            check("t2_kind", ek4, 1);
            check("t2_data", ed4, b*16 + i);
         end
      end
      tick();
      check("t2_idle", ev4, 0);

      // overflow: output register held by a core-0 event, then 6 PUTC
      er4 = 1'b0;
      put4(0, I_REP, 32'hAA);
      tick(); clr();
      for (int k = 0; k < 6; k++) begin
         put4(1, I_PUTC, 32'(32'h100 + k));
         tick(); clr();
         if (k == 3) check("t3_ovf_4th", ov4, 4'b0000);
         if (k == 4) check("t3_ovf_5th", ov4, 4'b0010);
      end
      check("t3_hold_valid", ev4, 1);
      check("t3_hold_core", ec4, 0);
      check("t3_hold_data", ed4, 32'hAA);
      er4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_valid", ev4, 1);
         check("t3_core", ec4, 1);
         check("t3_kind", ek4, 2);
         check("t3_data", ed4, 32'h100 + i);
      end
      tick();
      check("t3_empty", ev4, 0);
      check("t3_sticky", ov4, 4'b0010);

      // backpressure; pointer sits at core 2 after the last winner 1
      order = '{2, 3, 0, 1};
      er4 = 1'b0;
      for (int c = 0; c < 4; c++) put4(c, I_PUTC, 32'(32'h200 + c));
      tick(); clr();
      got = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (got < 4) begin
            check("bp_valid", ev4, 1);
            check("bp_core", ec4, order[got]);
            check("bp_data", ed4, 32'h200 + order[got]);
         end else begin
            check("bp_idle", ev4, 0);
         end
         er4 = (c % 2 == 1);
         if (ev4 && er4) got++;
      end
      check("bp_count", got, 4);

      // asynchronous reset with events pending
      er4 = 1'b0;
      for (int c = 0; c < 4; c++) put4(c, I_REP, 32'(32'h300 + c));
      tick(); clr();
      tick();
      check("rs_pre_valid", ev4, 1);
      check("rs_pre_data", ed4, 32'h302);
      rst = 1'b1;
      #1;
      check("rs_valid", ev4, 0);
      check("rs_core", ec4, 0);
      check("rs_kind", ek4, 0);
      check("rs_data", ed4, 0);
      check("rs_ovf", ov4, 0);
      tick();
      rst = 1'b0;
      er4 = 1'b1;
      tick(); tick();
      check("rs_stale", ev4, 0);
      check("rs_ovf_after", ov4, 0);

      // termination
      put4(0, I_EXIT, 32'h55);
      tick(); clr();
      check("tm_term0", tm4, 4'b0001);
      check("tm_gap", ev4, 0);
      for (int k = 0; k < 3; k++) begin
         put4(0, I_REP, 32'(32'h60 + k));
         tick(); clr();
         if (k == 0) begin
            check("tm_exit_valid", ev4, 1);
            check("tm_exit_kind", ek4, 0);
            check("tm_exit_core", ec4, 0);
            check("tm_exit_data", ed4, 32'h55);
         end else begin
            check("tm_ignored", ev4, 0);
         end
      end
      tick();
      check("tm_ignored_last", ev4, 0);
      check("tm_allterm_0", at4, 0);
      put4(1, I_EXIT, 32'h1);
      put4(2, I_EXIT, 32'h2);
      tick(); clr();
      check("tm_term012", tm4, 4'b0111);
      put4(3, I_EXIT, 32'h3);
      tick(); clr();
      check("tm_term_all", tm4, 4'b1111);
      check("tm_allterm_lag", at4, 0);
      tick();
      check("tm_allterm", at4, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
